// File: rtl/iccm_prog_pkg.sv
// rtl/iccm_prog_pkg.sv - shared types and constants for the ICCM program loader
package iccm_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } prog_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_BYTES = 2;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with runtime clocks-per-bit divisor
module uart_rx_core #(
  parameter int CpbWidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CpbWidth-1:0] cpb,
  input  logic                rx,
  output logic [7:0]          rx_byte,
  output logic                valid,
  output logic                frame_err
);
  import iccm_prog_pkg::*;

  logic                rx_s1, rx_s2, rx_s3;
  rx_state_e           state, state_nx;
  logic [CpbWidth-1:0] cnt, cnt_nx;
  logic [2:0]          bit_idx, bit_nx;
  logic [7:0]          shift, shift_nx;
  logic                valid_nx, ferr_nx;

  assign rx_byte = shift;

  // Two-flop synchroniser on the pin, plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_nx;
      shift     <= shift_nx;
      valid     <= valid_nx;
      frame_err <= ferr_nx;
    end
  end

  // Bit timing: half-bit to the start-bit centre, then one full bit period per sample
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    valid_nx = 1'b0;
    ferr_nx  = frame_err;
    case (state)
      RX_IDLE: begin
        if (rx_s3 && !rx_s2) begin
          state_nx = RX_START;
          cnt_nx   = (cpb >> 1) - 1'b1;
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (!rx_s2) begin
          state_nx = RX_BITS;
          cnt_nx   = cpb - 1'b1;
          bit_nx   = '0;
        end else begin
          // line went back high: glitch, not a start bit
          state_nx = RX_IDLE;
        end
      end
      RX_BITS: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          shift_nx = {rx_s2, shift[7:1]};
          cnt_nx   = cpb - 1'b1;
          bit_nx   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          valid_nx = 1'b1;
          ferr_nx  = !rx_s2;
          state_nx = RX_IDLE;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/iccm_prog_loader.sv
// rtl/iccm_prog_loader.sv - UART boot loader streaming a framed image into ICCM
module iccm_prog_loader #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 12,
  parameter int CpbWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 prog_i,
  input  logic [CpbWidth-1:0]  clks_per_bit_i,
  input  logic                 rx_i,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 prog_rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);
  import iccm_prog_pkg::*;

  localparam int BytesPerWord = DataWidth / 8;
  localparam int BcWidth      = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam logic [BcWidth-1:0] LastByte = BcWidth'(BytesPerWord - 1);
  // Largest legal word count; with 16+ address bits every 16-bit count fits
  localparam logic [16:0] MaxWords = (AddrWidth >= 16) ? 17'h1_0000 : (17'd1 << AddrWidth);

  prog_state_e          state, state_nx;
  logic                 prog_q;
  logic [CpbWidth-1:0]  cpb_q;
  logic [7:0]           len_lo;
  logic                 len_cnt;
  logic [15:0]          rem;
  logic [BcWidth-1:0]   byte_cnt;
  logic [AddrWidth-1:0] idx;
  logic [DataWidth-1:0] word, word_nx;
  logic [7:0]           csum;

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;
  logic        prog_rise, prog_fall, active, session_start, accept, len_last;
  logic [15:0] len_full;

  uart_rx_core #(.CpbWidth(CpbWidth)) u_rx (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .cpb       (cpb_q),
    .rx        (rx_i),
    .rx_byte   (rx_byte),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  assign prog_rise     = prog_i & ~prog_q;
  assign prog_fall     = ~prog_i & prog_q;
  assign active        = (state == SYNC) || (state == LEN) || (state == DATA) || (state == CSUM);
  assign session_start = prog_rise && !active;
  assign accept        = active && rx_valid && !rx_ferr && !prog_fall;
  assign len_full      = {rx_byte, len_lo};
  assign len_last      = (len_cnt == 1'(LEN_BYTES - 1));

  assign busy_o      = active;
  assign done_o      = (state == DONE);
  assign err_o       = (state == ERR);
  assign prog_rst_no = !(active || (state == ERR));

  // Merge the incoming byte into its little-endian lane of the word being built
  always_comb begin
    word_nx = word;
    word_nx[int'(byte_cnt) * 8 +: 8] = rx_byte;
  end

  // Frame state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  // Frame sequencing; aborts (prog drop, framing error) take priority over byte decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (prog_rise) state_nx = SYNC;
      end
      default: begin
        if (prog_fall || (rx_valid && rx_ferr)) begin
          state_nx = ERR;
        end else if (rx_valid) begin
          case (state)
            SYNC: if (rx_byte == SYNC_BYTE) state_nx = LEN;
            LEN: begin
              if (len_last) begin
                if ({1'b0, len_full} > MaxWords) state_nx = ERR;
                else if (len_full == 16'd0)     state_nx = CSUM;
                else                            state_nx = DATA;
              end
            end
            DATA: if (byte_cnt == LastByte && rem == 16'd1) state_nx = CSUM;
            CSUM: state_nx = (rx_byte == csum) ? DONE : ERR;
            default: state_nx = state;
          endcase
        end
      end
    endcase
  end

  // Session datapath: divisor latch, length capture, word assembly, checksum, write strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_q   <= 1'b0;
      cpb_q    <= CpbWidth'(4);
      len_lo   <= '0;
      len_cnt  <= 1'b0;
      rem      <= '0;
      byte_cnt <= '0;
      idx      <= '0;
      word     <= '0;
      csum     <= '0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
    end else begin
      prog_q <= prog_i;
      we_o   <= 1'b0;
      if (session_start) begin
        cpb_q    <= clks_per_bit_i;
        len_cnt  <= 1'b0;
        byte_cnt <= '0;
        idx      <= '0;
        csum     <= '0;
      end else if (accept) begin
        case (state)
          LEN: begin
            len_lo  <= rx_byte;
            len_cnt <= len_cnt + 1'b1;
            rem     <= len_full;
          end
          DATA: begin
            word <= word_nx;
            csum <= csum ^ rx_byte;
            if (byte_cnt == LastByte) begin
              byte_cnt <= '0;
              we_o     <= 1'b1;
              addr_o   <= idx;
              wdata_o  <= word_nx;
              idx      <= idx + 1'b1;
              rem      <= rem - 16'd1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iccm_prog_loader.sv
// tb/tb_iccm_prog_loader.sv - scoreboard bench for the ICCM program loader
module tb_iccm_prog_loader;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int CW  = 16;
  localparam int BPW = DW / 8;
  localparam int O_DONE = 0;
  localparam int O_ERR  = 1;
  localparam int O_INC  = 2;

  typedef logic [7:0] bq_t[$];
  typedef logic [DW-1:0] wq_t[$];
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog = 1'b0;
  logic          rx = 1'b1;
  logic [CW-1:0] cpb = 16'd4;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          prog_rst_n, busy, done, err;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  iccm_prog_loader #(.DataWidth(DW), .AddrWidth(AW), .CpbWidth(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .prog_i         (prog),
    .clks_per_bit_i (cpb),
    .rx_i           (rx),
    .we_o           (we),
    .addr_o         (addr),
    .wdata_o        (wdata),
    .prog_rst_no    (prog_rst_n),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr, wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(addr), 64'(e.a));
        check("write_data", 64'(wdata), 64'(e.d));
      end
    end
  end

  // Reference: parse the byte stream by the frame rules, queue the writes it implies
  function automatic int model_frame(input bq_t b);
    int            i;
    int            n;
    logic [7:0]    cs;
    logic [DW-1:0] w;
    i  = 0;
    cs = 8'h00;
    while (i < b.size() && b[i] != 8'hA5) i++;
    if (i >= b.size()) return O_INC;
    i++;
    if (i + 2 > b.size()) return O_INC;
    n = int'(b[i]) + 256 * int'(b[i+1]);
    i += 2;
    if (n > (1 << AW)) return O_ERR;
    for (int k = 0; k < n; k++) begin
      if (i + BPW > b.size()) return O_INC;
      w = '0;
      for (int j = 0; j < BPW; j++) begin
        w  = w | (DW'(b[i+j]) << (8 * j));
        cs = cs ^ b[i+j];
      end
      exp_q.push_back('{a: AW'(k), d: w});
      i += BPW;
    end
    if (i >= b.size()) return O_INC;
    return (b[i] == cs) ? O_DONE : O_ERR;
  endfunction

  function automatic bq_t build_frame(input wq_t words, input logic [7:0] delta);
    bq_t        b;
    logic [7:0] cs;
    logic [DW-1:0] w;
    cs = 8'h00;
    b.push_back(8'hA5);
    b.push_back(8'(words.size()));
    b.push_back(8'(words.size() >> 8));
    foreach (words[k]) begin
      w = words[k];
      for (int j = 0; j < BPW; j++) begin
        b.push_back(w[8*j +: 8]);
        cs = cs ^ w[8*j +: 8];
      end
    end
    b.push_back(cs ^ delta);
    return b;
  endfunction

  task automatic uart_byte(input logic [7:0] b, input int c, input logic stop);
    rx = 1'b0;
    repeat (c) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (c) @(negedge clk);
    end
    rx = stop;
    repeat (c) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_bytes(input bq_t b, input int c);
    foreach (b[k]) uart_byte(b[k], c, 1'b1);
  endtask

  task automatic start_session(input int c);
    prog = 1'b0;
    @(negedge clk);
    cpb  = CW'(c);
    prog = 1'b1;
    repeat (2) @(negedge clk);
    check("start_busy", 64'(busy), 64'd1);
    check("start_prog_rst_n", 64'(prog_rst_n), 64'd0);
    check("start_done", 64'(done), 64'd0);
    check("start_err", 64'(err), 64'd0);
  endtask

  task automatic expect_end(input int outcome);
    repeat (4) @(negedge clk);
    check("end_done", 64'(done), (outcome == O_DONE) ? 64'd1 : 64'd0);
    check("end_err", 64'(err), (outcome == O_ERR) ? 64'd1 : 64'd0);
    check("end_prog_rst_n", 64'(prog_rst_n), (outcome == O_DONE) ? 64'd1 : 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frame(input bq_t b, input int c, input int exp_outcome);
    int m;
    m = model_frame(b);
    start_session(c);
    send_bytes(b, c);
    expect_end((exp_outcome < 0) ? m : exp_outcome);
  endtask

  task automatic check_reset_values();
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_prog_rst_n", 64'(prog_rst_n), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
  endtask

  initial begin
    bq_t good, b, pre;
    wq_t words;
    int  c, m;

    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    good = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

    // good frame
    run_frame(good, 4, O_DONE);

    // bad checksum: both words still written
    b = good;
    b[b.size()-1] = 8'h2B;
    run_frame(b, 4, O_ERR);

    // oversize length 0x1001
    run_frame('{8'hA5, 8'h01, 8'h10}, 4, O_ERR);

    // noise before sync
    b = good;
    b.push_front(8'hFF);
    b.push_front(8'h00);
    run_frame(b, 4, O_DONE);

    // empty image
    run_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 4, O_DONE);

    // randomized frames, divisors and occasional checksum corruption
    for (int r = 0; r < 5; r++) begin
      words.delete();
      repeat ($urandom_range(1, 3)) words.push_back(DW'($urandom));
      b = build_frame(words, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      run_frame(b, $urandom_range(4, 7), -1);
    end

    // short low glitch mid-DATA must not produce a byte
    c = 6;
    m = model_frame(good);
    start_session(c);
    pre = good[0:4];
    send_bytes(pre, c);
    repeat (4) @(negedge clk);
    rx = 1'b0;
    repeat (c / 2 - 1) @(negedge clk);
    rx = 1'b1;
    repeat (3 * c) @(negedge clk);
    pre = good[5:$];
    send_bytes(pre, c);
    expect_end(O_DONE);

    // stop bit 0 during DATA
    pre = good[0:7];
    m = model_frame(pre);
    start_session(4);
    send_bytes(pre, 4);
    uart_byte(8'hBE, 4, 1'b0);
    expect_end(O_ERR);

    // prog_i falls mid-DATA
    pre = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    m = model_frame(pre);
    start_session(5);
    send_bytes(pre, 5);
    repeat (2) @(negedge clk);
    prog = 1'b0;
    expect_end(O_ERR);

    // rst_ni pulsed mid-DATA
    m = model_frame(pre);
    start_session(4);
    send_bytes(pre, 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    prog  = 1'b0;
    @(negedge clk);
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values();
    check("pending_after_reset", 64'(exp_q.size()), 64'd0);

    // full session after reset
    run_frame(good, 4, O_DONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iccm_prog_loader.md
# iccm_prog_loader

Parametrised UART boot loader that streams a framed program image into instruction memory while holding the core in reset. It replaces the fixed 8-bit/12-bit ICCM controller and its hard-coded-baud receiver with configurable data/address widths, a runtime baud divisor, an explicit length header, a checksum, and error reporting. It sits between the board UART RX pin and the ICCM adapter's controller write port. Its `prog_rst_no` output feeds the reset manager.

## Interface
- `DataWidth`, 32: ICCM word width; multiple of 8, range 8..64.
- `AddrWidth`, 12: ICCM word-address width.
- `CpbWidth`, 16: width of the clocks-per-bit divisor.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset, asynchronous, active-low (power-on reset, not system reset).
- `prog_i` in 1: programming request; level, synchronous to `clk_i`; its rising edge starts a session.
- `clks_per_bit_i` in CpbWidth: UART bit period in clocks; minimum 4; latched on session start.
- `rx_i` in 1: UART serial input; asynchronous; idle high.
- `we_o` out 1: one-cycle ICCM write strobe.
- `addr_o` out AddrWidth: ICCM word address.
- `wdata_o` out DataWidth: ICCM write data.
- `prog_rst_no` out 1: core reset request, active-low.
- `busy_o` out 1: session in progress.
- `done_o` out 1: last session succeeded; sticky.
- `err_o` out 1: last session failed; sticky.

## Operation
- **Frame format:** sync byte 0xA5; 2-byte little-endian word count N; N words of DataWidth/8 bytes each, little-endian; 1 checksum byte equal to the XOR of all data bytes.
- **IDLE:** waits for a rising edge of `prog_i`. On that edge: latch `clks_per_bit_i`, clear `done_o`/`err_o`, drive `prog_rst_no`=0, reset the word index and checksum, go to SYNC.
- **SYNC:** discards any byte other than 0xA5. On 0xA5 go to LEN.
- **LEN:** collects 2 bytes.
  - If N > 2^AddrWidth, go to ERR.
  - If N == 0, go to CSUM.
  - Otherwise go to DATA.
- **DATA:** shifts each byte into a word, little-endian, and XORs it into the checksum.
  - When a word completes: pulse `we_o` with `addr_o` = word index, then increment the index.
  - After word N, go to CSUM.
- **CSUM:** one byte.
  - Match: go to DONE, `done_o`=1, `prog_rst_no`=1.
  - Mismatch: go to ERR.
- **ERR:** `err_o`=1, `prog_rst_no` held 0. Words already written are not rolled back.
- **DONE / ERR:** a new `prog_i` rising edge restarts the session from IDLE-entry actions.
- **`prog_i` falls** in SYNC/LEN/DATA/CSUM: go to ERR (abort).
- **UART framing error** (stop bit sampled 0) in any active state: go to ERR.
- **Receiver (uart_rx_core):** 8N1 with a 2-flop synchroniser on `rx_i`.
  - Falling edge starts a half-bit wait of `cpb>>1` cycles. If the line is high at that point, the start is false; return to idle with no byte.
  - 8 data bits are sampled LSB first, at `cpb`-cycle intervals.
  - The stop bit is sampled after a further `cpb` cycles.
  - Emits a `valid` pulse with the byte and a `frame_err` flag.
- **Reset values:** `we_o`=0, `addr_o`=0, `wdata_o`=0, `prog_rst_no`=1, `busy_o`=0, `done_o`=0, `err_o`=0. State is IDLE.
- `rst_ni` asserted mid-session aborts immediately to the reset values.

## Timing
- `we_o` is high exactly one cycle: the cycle after the receiver `valid` pulse for a word's last byte.
- `addr_o` and `wdata_o` are valid in that cycle and hold until the next write.
- Byte latency is about 9.5·cpb + 3 cycles from the start-bit falling edge, including the synchroniser.
- State transitions occur in the cycle after the receiver `valid` pulse.
- `prog_rst_no` goes low the cycle after the `prog_i` rising edge is detected.
- `prog_rst_no` goes high in the cycle the checksum matches.
- `busy_o` is 1 in SYNC, LEN, DATA and CSUM.
- Index wrap: index 2^AddrWidth − 1 is the last legal write. Counting past it is impossible because of the length check.

## Structure
- `iccm_prog_pkg` holds:
  - the state enum `prog_state_e` {IDLE, SYNC, LEN, DATA, CSUM, DONE, ERR};
  - `SYNC_BYTE` = 8'hA5;
  - `LEN_BYTES` = 2.
- Sub-module `uart_rx_core` (divisor input, byte, `valid`, `frame_err`) is natural and reusable by the UART block.
- The top level holds the frame FSM, byte-within-word counter, word index, and checksum register.

## Test plan
- **Good frame:** cpb=4; send prog↑, A5, 02 00, 78 56 34 12, EF BE AD DE, 2A.
  - Expect `we_o`@addr 0 data 0x12345678, then `we_o`@addr 1 data 0xDEADBEEF.
  - Expect `done_o`=1, `prog_rst_no`=1.
- **Bad checksum:** same frame with checksum 2B.
  - Both writes still occur; `err_o`=1, `done_o`=0, `prog_rst_no`=0.
- **Oversize length:** AddrWidth=12, length 01 10 (N=0x1001).
  - ERR after the second length byte; no `we_o`.
- **Noise before sync:** send 00, FF before A5.
  - Both bytes ignored; remainder of scenario 1 yields identical writes.
- **Receiver robustness:**
  - `rx_i` low for cpb/2−1 cycles: no byte.
  - Byte with stop bit 0 during DATA: `err_o`=1.
- **Abort / reset:**
  - `prog_i` falls mid-DATA: `err_o`=1.
  - `rst_ni` pulsed mid-DATA: all outputs at reset values, `prog_rst_no`=1.
  - A subsequent full session succeeds.
